vtram_arb: RTL and testbench
============================

# vtram_arb

Two-master Wishbone arbiter that shares the terminal program/data memory (16-bit, byte-selectable, 2 KW) between the terminal CPU (master 0) and the host-side loader/debug port (master 1). It sits between both masters and the single memory slave, grants the slave to one master per bus cycle with round-robin fairness, and routes strobes and acks accordingly. It also guards against a missing slave ack with a timeout error.

## Interface
- TMO, 16: slave-ack timeout in clock cycles (1..255); 0 disables timeout.
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- m0_adr_i / m1_adr_i  in  16  master byte address.
- m0_dat_i / m1_dat_i  in  16  master write data.
- m0_dat_o / m1_dat_o  out  16  read data; both driven from s_dat_i.
- m0_cyc_i / m1_cyc_i  in  1  bus cycle request; held for the whole transfer.
- m0_stb_i / m1_stb_i  in  1  transfer strobe.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_sel_i / m1_sel_i  in  2  byte selects.
- m0_ack_o / m1_ack_o  out  1  transfer acknowledge.
- m0_err_o / m1_err_o  out  1  timeout error, one-cycle pulse.
- s_adr_o, s_dat_o  out  16  address/data to memory.
- s_dat_i  in  16  memory read data.
- s_cyc_o, s_stb_o, s_we_o  out  1  memory controls.
- s_sel_o  out  2  memory byte selects.
- s_ack_i  in  1  memory acknowledge.
- gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle.

## Operation
- States: IDLE, GNT0, GNT1; registered. `last` flag records the last master granted.
- IDLE: if only mX_cyc_i is high, go to GNTx. If both are high, grant the master not equal to `last`. `last` resets to 1, so m0 wins the first contention.
- GNTx: hold while mx_cyc_i = 1 (the bus stays locked across multiple stb beats). When mx_cyc_i = 0 at the edge, go to GNTy if my_cyc_i = 1, else IDLE. Set `last` = x on entry to GNTx.
- Slave mux, combinational from state:
  - s_cyc_o = mx_cyc_i and s_stb_o = mx_stb_i & mx_cyc_i of the granted master.
  - adr/dat/we/sel come from the granted master.
  - In IDLE, s_cyc_o = s_stb_o = s_we_o = 0, s_sel_o = 00, and adr/dat = 0.
- Ack routing: mx_ack_o = s_ack_i & (state == GNTx) & mx_stb_i. The non-granted master never sees ack.
- Timeout (TMO ≠ 0):
  - 8-bit counter clears on any cycle with s_ack_i = 1 or s_stb_o = 0, and increments while s_stb_o & ~s_ack_i.
  - When the count reaches TMO-1, pulse mx_err_o = 1 for one cycle to the granted master and clear the counter.
  - ack and err are never both high.
- Reset (asynchronous, any time, including mid-transfer): state = IDLE, `last` = 1, counter = 0. All outputs then read 0: gnt_o = 00, s_cyc_o = s_stb_o = s_we_o = 0, all acks/errs = 0. An interrupted transfer is simply dropped.

## Timing
- Grant latency: a request seen in IDLE at edge N gives a grant (gnt_o, s_cyc_o) in cycle N+1. A master already granted sees no added latency on further beats.
- Memory slave behaviour:
  - Writes ack in the same cycle as stb.
  - Reads ack in the third cycle of stb, with data valid in the ack cycle.
- End-to-end latency from master request in IDLE:
  - Write: ack in cycle 1.
  - Read: ack in cycle 3.
- Handover: the granted master drops cyc in cycle K, the other master is granted in cycle K+1. There is no idle cycle when the other is waiting.
- Error pulse for a stalled strobe appears in the TMO-th cycle of s_stb_o without ack.

## Test plan
- Single read, m0 only: m0 reads 0x0010 (mem = 0x1234) from IDLE at cycle 0. Required: gnt_o = 01 in cycle 1, m0_ack_o high in cycle 3 only, m0_dat_o = 0x1234, m1_ack_o = 0 throughout.
- Byte write, m1: m1 writes 0xABCD to 0x0020 with sel = 10. Required: s_sel_o = 10 and s_we_o = 1 in cycle 1, m1_ack_o in cycle 1. A later read of 0x0020 returns high byte 0xAB with the low byte unchanged.
- Contention after reset: both cyc high at cycle 0. Required: m0 is granted first. m0 drops cyc at cycle 5, and gnt_o = 10 in cycle 6 without an idle gap. With both requesting again from IDLE, m0 wins next, because `last` = 1 and m1 was served most recently.
- Bus lock: m0 holds cyc over 3 read beats while m1 requests continuously. Required: gnt_o stays 01 until m0_cyc_i drops, and m1 receives no ack.
- Timeout: TMO = 16, slave ack tied low, m1 strobes. Required: m1_err_o high exactly in the 16th stb cycle for one cycle, no ack, and the counter restarts afterwards.
- Reset mid-read: assert wb_rst_i in cycle 2 of an m0 read. Required: immediately s_cyc_o = 0 and gnt_o = 00 with no ack. After release, m1 alone is granted normally.

Source files
------------

// File: rtl/vtram_arb.sv
// Round-robin Wishbone arbiter: two masters share one 16-bit memory slave, with an
// optional slave-ack timeout that returns a one-cycle error to the granted master.
module vtram_arb #(
  parameter int unsigned TMO = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [15:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [15:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [1:0]  s_sel_o,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  localparam logic [7:0] TmoLast = 8'(TMO - 1);
  localparam logic       TmoEn   = (TMO != 0);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        // On contention the master that was not served last wins
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? StGnt0 : StGnt1;
        else if (m0_cyc_i)        state_d = StGnt0;
        else if (m1_cyc_i)        state_d = StGnt1;
      end
      StGnt0:  if (!m0_cyc_i) state_d = m1_cyc_i ? StGnt1 : StIdle;
      StGnt1:  if (!m1_cyc_i) state_d = m0_cyc_i ? StGnt0 : StIdle;
      default: state_d = StIdle;
    endcase
    last_d = last_q;
    if (state_d == StGnt0)      last_d = 1'b0;
    else if (state_d == StGnt1) last_d = 1'b1;
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 2'b00;
    s_adr_o = 16'h0000;
    s_dat_o = 16'h0000;
    case (state_q)
      StGnt0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & m0_cyc_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      StGnt1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & m1_cyc_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // Counter value k means the current strobe has gone k+1 cycles without ack
  assign tmo_hit = TmoEn & s_stb_o & ~s_ack_i & (cnt_q == TmoLast);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!TmoEn || !s_stb_o || s_ack_i || tmo_hit) cnt_d = 8'd0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o    = {state_q == StGnt1, state_q == StGnt0};
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & (state_q == StGnt0) & m0_stb_i;
  assign m1_ack_o = s_ack_i & (state_q == StGnt1) & m1_stb_i;
  assign m0_err_o = tmo_hit & (state_q == StGnt0);
  assign m1_err_o = tmo_hit & (state_q == StGnt1);

endmodule

// File: tb/tb_vtram_arb.sv
// Directed bench for vtram_arb with a small memory slave model: writes ack with the
// strobe, reads ack in the third strobe cycle.
module tb_vtram_arb;

  logic        wb_clk_i, wb_rst_i;
  logic [15:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [1:0]  m0_sel_i, m1_sel_i, s_sel_o, gnt_o;
  logic [15:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;

  logic [15:0] mem [0:2047];
  logic [1:0]  rd_cnt;
  logic        ack_en;
  int          checks, failures;

  vtram_arb #(.TMO(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  assign s_ack_i = ack_en & s_stb_o & (s_we_o | (rd_cnt == 2'd2));
  assign s_dat_i = mem[s_adr_o[11:1]];

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mem[8]  <= 16'h1234;
      mem[16] <= 16'h5566;
    end else if (s_stb_o && s_we_o && s_ack_i) begin
      if (s_sel_o[0]) mem[s_adr_o[11:1]][7:0]  <= s_dat_o[7:0];
      if (s_sel_o[1]) mem[s_adr_o[11:1]][15:8] <= s_dat_o[15:8];
    end
    if (s_stb_o && !s_we_o && !s_ack_i) rd_cnt <= rd_cnt + 2'd1;
    else                                rd_cnt <= 2'd0;
  end

  task automatic nc();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge wb_clk_i);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m0_set(input logic cyc, input logic we, input logic [15:0] adr);
    m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we; m0_adr_i = adr; m0_sel_i = 2'b11;
  endtask

  task automatic m1_set(input logic cyc, input logic we, input logic [15:0] adr,
                        input logic [15:0] dat, input logic [1:0] sel);
    m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    m1_sel_i = sel;
  endtask

  initial begin
    checks = 0; failures = 0;
    wb_rst_i = 1'b1; ack_en = 1'b1; m0_dat_i = 16'h0;
    m0_set(1'b0, 1'b0, 16'h0);
    m1_set(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    smp(); smp();
    chk("rst_gnt", 16'(gnt_o), 16'h0);
    chk("rst_s_cyc", 16'(s_cyc_o), 16'h0);
    chk("rst_s_stb", 16'(s_stb_o), 16'h0);
    chk("rst_s_we", 16'(s_we_o), 16'h0);
    chk("rst_m0_ack", 16'(m0_ack_o), 16'h0);
    chk("rst_m1_err", 16'(m1_err_o), 16'h0);
    nc(); wb_rst_i = 1'b0;
    nc();

    // Single read by m0
    m0_set(1'b1, 1'b0, 16'h0010);
    smp(); chk("rd_c0_gnt", 16'(gnt_o), 16'h0);
    for (int c = 1; c <= 3; c++) begin
      nc(); smp();
      chk("rd_gnt", 16'(gnt_o), 16'h1);
      chk("rd_m0_ack", 16'(m0_ack_o), 16'(c == 3));
      chk("rd_m1_ack", 16'(m1_ack_o), 16'h0);
    end
    chk("rd_data", m0_dat_o, 16'h1234);
    nc(); m0_set(1'b0, 1'b0, 16'h0);
    nc();

    // Upper-byte write by m1
    m1_set(1'b1, 1'b1, 16'h0020, 16'hABCD, 2'b10);
    nc(); smp();
    chk("wr_sel", 16'(s_sel_o), 16'h2);
    chk("wr_we", 16'(s_we_o), 16'h1);
    chk("wr_m1_ack", 16'(m1_ack_o), 16'h1);
    chk("wr_gnt", 16'(gnt_o), 16'h2);
    nc(); m1_set(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    nc();
    m0_set(1'b1, 1'b0, 16'h0020);
    nc(); nc(); nc(); smp();
    chk("rb_m0_ack", 16'(m0_ack_o), 16'h1);
    chk("rb_data", m0_dat_o, 16'hAB66);
    nc(); m0_set(1'b0, 1'b0, 16'h0);
    nc();

    // Contention right after reset
    wb_rst_i = 1'b1; nc(); wb_rst_i = 1'b0; nc();
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    nc(); smp(); chk("cont_c1_gnt", 16'(gnt_o), 16'h1);
    nc(); nc(); nc(); nc();
    m0_cyc_i = 1'b0;
    smp(); chk("cont_c5_gnt", 16'(gnt_o), 16'h1);
    nc(); smp(); chk("cont_c6_handover", 16'(gnt_o), 16'h2);
    nc(); m1_cyc_i = 1'b0;
    nc(); smp(); chk("cont_idle", 16'(gnt_o), 16'h0);
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    nc(); smp(); chk("cont_rr_m0", 16'(gnt_o), 16'h1);
    m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
    nc();

    // Bus lock: m0 three read beats while m1 keeps requesting
    m0_set(1'b1, 1'b0, 16'h0010);
    for (int c = 1; c <= 9; c++) begin
      nc();
      if (c == 1) m1_set(1'b1, 1'b0, 16'h0020, 16'h0, 2'b11);
      smp();
      chk("lock_gnt", 16'(gnt_o), 16'h1);
      chk("lock_m0_ack", 16'(m0_ack_o), 16'(c % 3 == 0));
      chk("lock_m1_ack", 16'(m1_ack_o), 16'h0);
    end
    nc(); m0_set(1'b0, 1'b0, 16'h0);
    smp(); chk("lock_drop_gnt", 16'(gnt_o), 16'h1);
    nc(); smp();
    chk("lock_m1_gnt", 16'(gnt_o), 16'h2);
    chk("lock_m0_ack_off", 16'(m0_ack_o), 16'h0);
    nc(); m1_set(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    nc();

    // Timeout with the slave never acking
    ack_en = 1'b0;
    m1_set(1'b1, 1'b1, 16'h0040, 16'h5A5A, 2'b11);
    for (int c = 1; c <= 33; c++) begin
      nc(); smp();
      chk("tmo_m1_err", 16'(m1_err_o), 16'(c == 16 || c == 32));
      chk("tmo_m1_ack", 16'(m1_ack_o), 16'h0);
      chk("tmo_m0_err", 16'(m0_err_o), 16'h0);
    end
    nc(); m1_set(1'b0, 1'b0, 16'h0, 16'h0, 2'b00); ack_en = 1'b1;
    nc();

    // Reset in the middle of an m0 read
    m0_set(1'b1, 1'b0, 16'h0010);
    nc(); nc();
    wb_rst_i = 1'b1;
    smp();
    chk("mrst_s_cyc", 16'(s_cyc_o), 16'h0);
    chk("mrst_gnt", 16'(gnt_o), 16'h0);
    chk("mrst_m0_ack", 16'(m0_ack_o), 16'h0);
    nc(); wb_rst_i = 1'b0; m0_set(1'b0, 1'b0, 16'h0);
    nc();
    m1_set(1'b1, 1'b1, 16'h0030, 16'h1111, 2'b11);
    nc(); smp();
    chk("mrst_m1_gnt", 16'(gnt_o), 16'h2);
    chk("mrst_m1_ack", 16'(m1_ack_o), 16'h1);
    nc(); m1_set(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    nc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
